// File: rtl/fast_move_key.sv
`default_nettype none
// ============================================================================
//  Module   : fast_move_key
//  Purpose  : Debounce and hold-detect for the active-low "fast move" key;
//             yields a registered hold level and a one-cycle press pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module fast_move_key #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic fast_move,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] C_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DB_PRESS   = 3'd1,
        S_PRESSED    = 3'd2,
        S_HELD       = 3'd3,
        S_DB_RELEASE = 3'd4
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             w_key_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_was_held;

    // Synchronizer idles at "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= key_n;
            r_s2 <= r_s1;
        end
    end

    assign w_key_s = ~r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_was_held  <= 1'b0;
            fast_move   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    fast_move <= 1'b0;
                    if (w_key_s) begin
                        r_state <= S_DB_PRESS;
                        r_cnt   <= '0;
                    end
                end
                S_DB_PRESS: begin
                    if (!w_key_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_DB_LAST) begin
                        r_state     <= S_PRESSED;
                        r_cnt       <= '0;
                        press_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_PRESSED: begin
                    if (!w_key_s) begin
                        r_state    <= S_DB_RELEASE;
                        r_cnt      <= '0;
                        r_was_held <= 1'b0;
                    end else if (r_cnt == C_HOLD_LAST) begin
                        r_state   <= S_HELD;
                        r_cnt     <= '0;
                        fast_move <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_HELD: begin
                    fast_move <= 1'b1;
                    if (!w_key_s) begin
                        r_state    <= S_DB_RELEASE;
                        r_cnt      <= '0;
                        r_was_held <= 1'b1;
                    end
                end
                S_DB_RELEASE: begin
                    // Output holds its pre-release value until the release is confirmed.
                    if (w_key_s) begin
                        r_state   <= r_was_held ? S_HELD : S_PRESSED;
                        r_cnt     <= '0;
                        fast_move <= r_was_held;
                    end else if (r_cnt == C_DB_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        fast_move <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    fast_move <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fast_move_key.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fast_move_key
//  Purpose  : Directed self-checking bench for fast_move_key (D=4, H=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fast_move_key;

    logic clk;
    logic reset_n;
    logic key_n;
    logic fast_move;
    logic press_pulse;

    int n_cmp = 0;
    int n_err = 0;

    fast_move_key #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .CNT_W          (25)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .fast_move  (fast_move),
        .press_pulse(press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s@edge%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_n   = 1'b1;

        // Reset held with the key toggling: outputs stay low.
        for (int k = 1; k <= 6; k++) begin
            key_n = k[0];
            tick();
            chk("rst_fm", k, fast_move, 1'b0);
            chk("rst_pp", k, press_pulse, 1'b0);
        end
        key_n   = 1'b1;
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("idle_pp", k, press_pulse, 1'b0);
        end

        // Clean tap: 12 cycles pressed.
        for (int k = 1; k <= 25; k++) begin
            key_n = (k <= 12) ? 1'b0 : 1'b1;
            tick();
            chk("tap_pp", k, press_pulse, (k == 7));
            chk("tap_fm", k, fast_move, 1'b0);
        end

        // Long hold, released at edge 30.
        for (int k = 1; k <= 40; k++) begin
            key_n = (k < 30) ? 1'b0 : 1'b1;
            tick();
            chk("hold_pp", k, press_pulse, (k == 7));
            chk("hold_fm", k, fast_move, (k >= 15 && k < 36));
        end

        // Press bounce, stable from edge 11, then 2-cycle release glitches while held.
        for (int k = 1; k <= 55; k++) begin
            case (k)
                2, 5, 7, 10, 30, 31, 38, 39: key_n = 1'b1;
                default:                     key_n = (k >= 45) ? 1'b1 : 1'b0;
            endcase
            tick();
            chk("bnc_pp", k, press_pulse, (k == 17));
            chk("bnc_fm", k, fast_move, (k >= 25 && k < 51));
        end

        // One-cycle glitch at edge 10 while PRESSED restarts the hold count.
        for (int k = 1; k <= 25; k++) begin
            key_n = (k == 10) ? 1'b1 : 1'b0;
            tick();
            chk("rpr_pp", k, press_pulse, (k == 7));
            chk("rpr_fm", k, fast_move, (k >= 21));
        end

        // Asynchronous reset mid-cycle while HELD.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_fm", 0, fast_move, 1'b0);
        chk("async_pp", 0, press_pulse, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            key_n = k[0];
            tick();
            chk("rst2_fm", k, fast_move, 1'b0);
        end

        // Key still held as reset releases: debounced as a fresh press.
        key_n   = 1'b0;
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("fresh_pp", k, press_pulse, (k == 7));
        end

        key_n = 1'b1;
        for (int k = 1; k <= 8; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
